// File: rtl/async_fifo_rd_stream.sv
// rtl/async_fifo_rd_stream.sv - FIFO read port to valid/ready stream adapter with output buffer
//
// Read-side consumer for async_fifo_flags in the rd_clk domain. Issues FIFO
// reads against a credit count (buffered entries plus the one read in flight)
// so the FIFO read strobe never depends on m_ready, and presents buffered
// words as a valid/ready stream at one beat per clock.
//
// Optional feature macro: ASYNC_FIFO_RD_STREAM_STALL_CNT_EN
//   defined   - stall_count counts cycles with m_valid=1 and m_ready=0
//               (saturating, cleared by rst or flush)
//   undefined - stall_count is tied to 0
//
// Ports:
//   clk          read-domain clock (FIFO rd_clk)
//   rst          asynchronous active-high reset
//   fifo_rd_en   read strobe to the FIFO
//   fifo_rd_data FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty   FIFO empty flag
//   flush        synchronous discard of buffered and in-flight data
//   m_valid      stream beat valid
//   m_ready      downstream accept
//   m_data       stream beat data
//   occupancy    buffered entries, excluding the in-flight read
//   stall_count  stalled-beat cycle counter (optional feature)

module async_fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic                               fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]              fifo_rd_data,
    input  logic                               fifo_empty,
    input  logic                               flush,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [DATA_WIDTH-1:0]              m_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     occupancy,
    output logic [CNT_WIDTH-1:0]               stall_count
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [OCC_W:0]   DEPTH_EXT = (OCC_W + 1)'(BUF_DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [OCC_W-1:0]      occ;
    logic                  pending;
    logic                  push;
    logic                  pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign push      = pending && !flush;
    assign pop       = m_valid && m_ready && !flush;
    assign m_valid   = (occ != '0);
    assign m_data    = buf_mem[head];
    assign occupancy = occ;

    // Credit check includes the read already in flight, so a returning word
    // always has a free slot. rst gates the strobe so it drops immediately.
    assign fifo_rd_en = !rst && !fifo_empty && !flush &&
                        (({1'b0, occ} + (OCC_W + 1)'(pending)) < DEPTH_EXT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            occ     <= '0;
            pending <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            pending <= fifo_rd_en;
            if (flush) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                if (push) begin
                    buf_mem[tail] <= fifo_rd_data;
                    tail          <= next_ptr(tail);
                end
                if (pop) begin
                    head <= next_ptr(head);
                end
                case ({push, pop})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: occ <= occ;
                endcase
            end
        end
    end

    // A capture into a full buffer would mean the credit check is broken.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (occ != DEPTH_OCC);
        end
    end

`ifdef ASYNC_FIFO_RD_STREAM_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (flush) begin
            stall_q <= '0;
        end else if (m_valid && !m_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule
